// File: rtl/mdu_if.sv
// Execute-stage handshake and HI/LO result bus between the pipeline and the mdu.
interface mdu_if;
  logic        start;
  logic        cancel;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (output start, cancel, op, a, b, input busy, hi, lo, rdata);
  modport slave  (input start, cancel, op, a, b, output busy, hi, lo, rdata);
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit: HI/LO registers with a down-counter modelling latency.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise ops 9-12 are no-ops.
module mdu #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } op_e;

  logic [31:0]   hi_q, lo_q, phi, plo;
  logic [CW-1:0] cnt;
  logic          pend;
  logic          go, long_op, res_ok, sgn;
  logic [CW-1:0] load;
  logic [63:0]   res;
  logic [63:0]   ext_a, ext_b, prod;
  logic          neg_a, neg_b;
  logic [31:0]   mag_a, mag_b, dvs, uq, ur, quo, rem;
`ifdef MDU_MADD_EN
  logic [63:0]   acc;
`endif

  assign go = bus.start & ~bus.cancel & (cnt == '0);

  always_comb begin
    sgn = 1'b0;
    case (bus.op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: sgn = 1'b1;
      default: sgn = 1'b0;
    endcase
  end

  // Sign/zero-extend to 64 bits so the low half of the product is exact for both signednesses.
  always_comb begin
    ext_a = {{32{sgn & bus.a[31]}}, bus.a};
    ext_b = {{32{sgn & bus.b[31]}}, bus.b};
    prod  = ext_a * ext_b;
  end

  // Divide on magnitudes, then restore signs; 0x80000000/-1 falls out as 0x80000000 rem 0.
  always_comb begin
    neg_a = sgn & bus.a[31];
    neg_b = sgn & bus.b[31];
    mag_a = neg_a ? 32'd0 - bus.a : bus.a;
    mag_b = neg_b ? 32'd0 - bus.b : bus.b;
    dvs   = (mag_b == '0) ? 32'd1 : mag_b;
    uq    = mag_a / dvs;
    ur    = mag_a % dvs;
    quo   = (neg_a ^ neg_b) ? 32'd0 - uq : uq;
    rem   = neg_a ? 32'd0 - ur : ur;
  end

`ifdef MDU_MADD_EN
  always_comb begin
    acc = {hi_q, lo_q};
  end
`endif

  always_comb begin
    long_op = 1'b0;
    res_ok  = 1'b0;
    res     = '0;
    load    = '0;
    case (bus.op)
      OP_MULT, OP_MULTU: begin
        long_op = 1'b1;
        res_ok  = 1'b1;
        res     = prod;
        load    = MUL_LOAD;
      end
      OP_DIV, OP_DIVU: begin
        long_op = 1'b1;
        res_ok  = (bus.b != '0);
        res     = {rem, quo};
        load    = DIV_LOAD;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        long_op = 1'b1;
        res_ok  = 1'b1;
        res     = acc + prod;
        load    = MUL_LOAD;
      end
      OP_MSUB, OP_MSUBU: begin
        long_op = 1'b1;
        res_ok  = 1'b1;
        res     = acc - prod;
        load    = MUL_LOAD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      phi  <= '0;
      plo  <= '0;
      pend <= 1'b0;
      cnt  <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1) && pend) begin
        hi_q <= phi;
        lo_q <= plo;
        pend <= 1'b0;
      end
    end else if (go) begin
      if (long_op) begin
        cnt  <= load;
        phi  <= res[63:32];
        plo  <= res[31:0];
        pend <= res_ok;
      end else if (bus.op == OP_MTHI) begin
        hi_q <= bus.a;
      end else if (bus.op == OP_MTLO) begin
        lo_q <= bus.a;
      end
    end
  end

  always_comb begin
    bus.busy  = (go & long_op) | (cnt != '0);
    bus.hi    = hi_q;
    bus.lo    = lo_q;
    bus.rdata = '0;
    case (bus.op)
      OP_MFHI: bus.rdata = hi_q;
      OP_MFLO: bus.rdata = lo_q;
      default: bus.rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops against a 64-bit arithmetic model.
module tb_mdu;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic clk = 1'b0;
  logic reset;
  mdu_if bus ();

  mdu #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  bit          m_pend;
  int          m_left;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit is_long(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] mul64(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_res = '0; m_pend = 0; m_left = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model over the edge.
  task automatic step(input bit st, input bit cn, input logic [3:0] o,
                      input logic [31:0] xa, input logic [31:0] xb);
    bit go;
    longint q, r;
    logic [63:0] uq, ur;
    logic [31:0] exp_rd;
    @(negedge clk);
    bus.start = st; bus.cancel = cn; bus.op = o; bus.a = xa; bus.b = xb;
    #2;
    go = st && !cn && (m_left == 0);
    exp_rd = (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0;
    check("busy", 32'(bus.busy), 32'((go && is_long(o)) || m_left != 0));
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    check("rdata", bus.rdata, exp_rd);
    if (m_left != 0) begin
      if (m_left == 1 && m_pend) {m_hi, m_lo} = m_res;
      m_left--;
    end else if (go) begin
      case (o)
        4'd1, 4'd2: begin
          m_res = mul64(o == 4'd1, xa, xb); m_pend = 1; m_left = MULN;
        end
        4'd3: begin
          m_pend = (xb != 0); m_left = DIVN;
          if (m_pend) begin
            q = longint'($signed(xa)) / longint'($signed(xb));
            r = longint'($signed(xa)) % longint'($signed(xb));
            m_res = {r[31:0], q[31:0]};
          end
        end
        4'd4: begin
          m_pend = (xb != 0); m_left = DIVN;
          if (m_pend) begin
            uq = {32'd0, xa} / {32'd0, xb};
            ur = {32'd0, xa} % {32'd0, xb};
            m_res = {ur[31:0], uq[31:0]};
          end
        end
        4'd5: m_hi = xa;
        4'd6: m_lo = xa;
`ifdef MDU_MADD_EN
        4'd9, 4'd10: begin
          m_res = {m_hi, m_lo} + mul64(o == 4'd9, xa, xb); m_pend = 1; m_left = MULN;
        end
        4'd11, 4'd12: begin
          m_res = {m_hi, m_lo} - mul64(o == 4'd11, xa, xb); m_pend = 1; m_left = MULN;
        end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    bus.start = 0; bus.cancel = 0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    model_reset();
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    step(1, 0, 4'd1, 32'hFFFFFFFE, 32'd3);
    idle(MULN);
    step(0, 0, 4'd0, 0, 0);
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFFA);

    step(1, 0, 4'd4, 32'd100, 32'd7);
    idle(DIVN);
    step(0, 0, 4'd0, 0, 0);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    step(1, 0, 4'd3, 32'hFFFFFFF9, 32'd2);
    idle(DIVN);
    step(0, 0, 4'd0, 0, 0);
    check("div_lo", bus.lo, 32'hFFFFFFFD);
    check("div_hi", bus.hi, 32'hFFFFFFFF);

    step(1, 0, 4'd5, 32'h11, 0);
    step(1, 0, 4'd6, 32'h22, 0);
    step(1, 0, 4'd3, 32'h1234, 32'd0);
    idle(DIVN);
    step(0, 0, 4'd0, 0, 0);
    check("div0_hi", bus.hi, 32'h11);
    check("div0_lo", bus.lo, 32'h22);

    step(1, 0, 4'd3, 32'h80000000, 32'hFFFFFFFF);
    idle(DIVN);
    step(0, 0, 4'd0, 0, 0);
    check("ovf_lo", bus.lo, 32'h80000000);
    check("ovf_hi", bus.hi, 32'h0);

    step(1, 1, 4'd1, 32'd5, 32'd6);
    check("cancel_busy", 32'(bus.busy), 32'd0);
    step(1, 0, 4'd1, 32'd7, 32'd8);
    step(1, 0, 4'd1, 32'd100, 32'd100);
    idle(MULN - 1);
    step(0, 0, 4'd0, 0, 0);
    check("ignored_lo", bus.lo, 32'd56);

    step(1, 0, 4'd5, 32'hDEADBEEF, 0);
    step(0, 0, 4'd7, 0, 0);
    check("mthi_rdata", bus.rdata, 32'hDEADBEEF);

    step(1, 0, 4'd3, 32'd100, 32'd7);
    step(0, 0, 4'd0, 0, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(DIVN + 2);
    check("midrst_nowrite", bus.lo, 32'd0);

`ifdef MDU_MADD_EN
    step(1, 0, 4'd5, 32'd0, 0);
    step(1, 0, 4'd6, 32'd5, 0);
    step(1, 0, 4'd9, 32'd2, 32'd3);
    idle(MULN);
    step(0, 0, 4'd0, 0, 0);
    check("madd_lo", bus.lo, 32'd11);
`else
    step(1, 0, 4'd9, 32'd2, 32'd3);
    check("madd_off_busy", 32'(bus.busy), 32'd0);
`endif

    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra, rb;
      int sel;
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) begin ra = ra & 32'hFF; rb = rb & 32'hF; end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           4'($urandom_range(0, 15)), ra, rb);
    end
    idle(DIVN + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
